// File: rtl/ceres_ram_arbiter_pkg.sv
// Shared types for the Ceres RAM arbiter: request/response bundles for
// wrapper-side grouping, the arbiter FSM state encoding and counter width.
package ceres_param;

  localparam int ARB_CNT_W    = 8;
  localparam int CERES_LINE_W = 128;
  localparam int CERES_ADDR_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                      valid;
    logic [CERES_ADDR_W-1:0]   addr;
    logic [CERES_LINE_W/8-1:0] wstrb;
    logic [CERES_LINE_W-1:0]   wdata;
  } ram_req_t;

  typedef struct packed {
    logic                    valid;
    logic [CERES_LINE_W-1:0] rdata;
  } ram_res_t;

endpackage

// File: rtl/ceres_ram_arbiter_rr_pick2.sv
// Two-way grant picker. Returns the index of the winning master (0 = m0,
// 1 = m1); the result is only meaningful when at least one valid is set.
// CERES_RAM_ARB_FIXED_PRIO_EN: when defined, m0 always wins a tie and
// last_grant is ignored; otherwise ties go to the master not granted last.
module ceres_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant
);

`ifdef CERES_RAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // m0 takes priority whenever it asks
  always_comb begin
    grant = ~valid[0];
  end
`else
  // single requester wins outright; a tie alternates
  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) grant = ~last_grant;
    else                grant = valid[1];
  end
`endif

endmodule

// File: rtl/ceres_ram_arbiter.sv
// Ceres RAM arbiter: shares one RAM between m0 (CPU) and m1 (DMA/loader).
// One access at a time; the arbiter counts the RAM read latency itself and
// returns a single-cycle response pulse to the owner. All outputs registered.
// Tie policy selected in ceres_rr_pick2 by CERES_RAM_ARB_FIXED_PRIO_EN.
module ceres_ram_arbiter
  import ceres_param::*;
#(
  parameter int LINE_W      = 128,
  parameter int ADDR_W      = 18,
  parameter int RAM_LATENCY = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [LINE_W/8-1:0] m0_wstrb_i,
  input  logic [LINE_W-1:0]   m0_wdata_i,
  output logic                m0_res_valid_o,
  output logic [LINE_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [LINE_W/8-1:0] m1_wstrb_i,
  input  logic [LINE_W-1:0]   m1_wdata_i,
  output logic                m1_res_valid_o,
  output logic [LINE_W-1:0]   m1_rdata_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [LINE_W-1:0]   ram_wdata_o,
  output logic [LINE_W/8-1:0] ram_wstrb_o,
  output logic                ram_rd_en_o,
  input  logic [LINE_W-1:0]   ram_rdata_i,
  output logic                busy_o
);

  localparam int STRB_W = LINE_W / 8;
  localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(RAM_LATENCY);
  localparam logic [ARB_CNT_W-1:0] CNT_ONE  = ARB_CNT_W'(1);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 255) begin : g_bad_latency
    $error("ceres_ram_arbiter: RAM_LATENCY must be within 1..255");
  end

  arb_state_e           state, state_n;
  logic [ARB_CNT_W-1:0] cnt, cnt_n;
  logic                 owner, owner_n;
  logic                 last_grant, last_n;
  logic                 grant;
  logic [ADDR_W-1:0]    addr_n;
  logic [LINE_W-1:0]    wdata_n, rdata0_n, rdata1_n;
  logic [STRB_W-1:0]    wstrb_n;
  logic                 rd_en_n, res0_n, res1_n;

  ceres_rr_pick2 u_pick (
    .valid      ({m1_valid_i, m0_valid_i}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // next-state and next-output decode; strobes and pulses default low
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    owner_n  = owner;
    last_n   = last_grant;
    addr_n   = ram_addr_o;
    wdata_n  = ram_wdata_o;
    wstrb_n  = '0;
    rd_en_n  = 1'b0;
    res0_n   = 1'b0;
    res1_n   = 1'b0;
    rdata0_n = m0_rdata_o;
    rdata1_n = m1_rdata_o;
    case (state)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          owner_n = grant;
          last_n  = grant;
          addr_n  = grant ? m1_addr_i  : m0_addr_i;
          wdata_n = grant ? m1_wdata_i : m0_wdata_i;
          wstrb_n = grant ? m1_wstrb_i : m0_wstrb_i;
          rd_en_n = ~|(grant ? m1_wstrb_i : m0_wstrb_i);
          cnt_n   = CNT_LOAD;
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_ONE;
        // last latency cycle: RAM data is valid now, hand it to the owner
        if (cnt == CNT_ONE) begin
          state_n = RESP;
          if (owner) begin
            res1_n   = 1'b1;
            rdata1_n = ram_rdata_i;
          end else begin
            res0_n   = 1'b1;
            rdata0_n = ram_rdata_i;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      ram_addr_o     <= '0;
      ram_wdata_o    <= '0;
      ram_wstrb_o    <= '0;
      ram_rd_en_o    <= 1'b0;
      m0_res_valid_o <= 1'b0;
      m1_res_valid_o <= 1'b0;
      m0_rdata_o     <= '0;
      m1_rdata_o     <= '0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      owner          <= owner_n;
      last_grant     <= last_n;
      ram_addr_o     <= addr_n;
      ram_wdata_o    <= wdata_n;
      ram_wstrb_o    <= wstrb_n;
      ram_rd_en_o    <= rd_en_n;
      m0_res_valid_o <= res0_n;
      m1_res_valid_o <= res1_n;
      m0_rdata_o     <= rdata0_n;
      m1_rdata_o     <= rdata1_n;
      busy_o         <= (state_n != IDLE);
    end
  end

`ifndef SYNTHESIS
  // the owner must keep its request up until the response pulse
  a_owner_holds_valid : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state == WAIT) |-> (owner ? m1_valid_i : m0_valid_i)
  ) else $warning("ceres_ram_arbiter: owner dropped valid before its response");
`endif

endmodule
